// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, optional odd/even parity, 1 or 2 stop bits,
// 3-sample mid-bit majority vote, with parity/framing error and break reporting.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 busy
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT
  } state_t;

  state_t               r_state;
  state_t               w_next_state;

  logic                 r_sync1;
  logic                 r_rx_s;
  logic                 r_rx_q;
  logic [CW-1:0]        r_cnt;
  logic                 r_v0;
  logic                 r_v1;
  logic [3:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit;
  logic                 r_stop0;
  logic                 r_stop_err;
  logic                 r_rx_valid;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_parity_err;
  logic                 r_frame_err;
  logic                 r_break_det;

  logic                 w_active;
  logic                 w_decide;
  logic                 w_bit;
  logic                 w_last_stop;
  logic                 w_first_stop;
  logic                 w_is_break;
  logic                 w_frame_err;
  logic                 w_valid_set;
  logic                 w_brk_set;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic par_mismatch(input logic [DATA_BITS-1:0] d, input logic p);
    if (PARITY == 1) return ~(^d ^ p);
    if (PARITY == 2) return (^d ^ p);
    return 1'b0;
  endfunction

  assign w_active = (r_state == S_START) || (r_state == S_DATA) ||
                    (r_state == S_PARITY) || (r_state == S_STOP);
  assign w_decide = w_active && (r_cnt == CW'(H + 1));
  // third vote is the live synchronised sample at the decision clock
  assign w_bit    = maj3(r_v0, r_v1, r_rx_s);

  assign w_last_stop  = (r_state == S_STOP) && w_decide && (r_bit_idx == 4'(STOP_BITS - 1));
  assign w_first_stop = (r_bit_idx == 4'd0) ? w_bit : r_stop0;
  assign w_is_break   = (r_shift == '0) && ((PARITY == 0) || !r_par_bit) && !w_first_stop;
  assign w_frame_err  = r_stop_err | ~w_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (!r_rx_s && r_rx_q) w_next_state = S_START;
      S_START:    if (w_decide) w_next_state = w_bit ? S_IDLE : S_DATA;
      S_DATA:
        if (w_decide && (r_bit_idx == 4'(DATA_BITS - 1)))
          w_next_state = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY:   if (w_decide) w_next_state = S_STOP;
      S_STOP:     if (w_last_stop) w_next_state = w_is_break ? S_BRK_WAIT : S_IDLE;
      S_BRK_WAIT: if (r_rx_s) w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state != S_IDLE);
    w_valid_set = w_last_stop && !w_is_break;
    w_brk_set   = w_last_stop && w_is_break;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1      <= 1'b0;
      r_rx_s       <= 1'b0;
      r_rx_q       <= 1'b0;
      r_cnt        <= '0;
      r_v0         <= 1'b0;
      r_v1         <= 1'b0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_par_bit    <= 1'b0;
      r_stop0      <= 1'b0;
      r_stop_err   <= 1'b0;
      r_rx_valid   <= 1'b0;
      r_rx_data    <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_break_det  <= 1'b0;
    end else begin
      r_sync1 <= rx;
      r_rx_s  <= r_sync1;
      r_rx_q  <= r_rx_s;

      // cnt free-runs across the whole frame so every bit decision lands one period apart
      if (!w_active || (r_cnt == CW'(CLKS_PER_BIT - 1))) r_cnt <= '0;
      else                                               r_cnt <= r_cnt + CW'(1);

      if (r_cnt == CW'(H - 1)) r_v0 <= r_rx_s;
      if (r_cnt == CW'(H))     r_v1 <= r_rx_s;

      if (r_state == S_START) r_stop_err <= 1'b0;

      if (w_decide) begin
        r_bit_idx <= (w_next_state != r_state) ? 4'd0 : r_bit_idx + 4'd1;
        case (r_state)
          S_DATA:   r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
          S_PARITY: r_par_bit <= w_bit;
          S_STOP: begin
            if (r_bit_idx == 4'd0) r_stop0 <= w_bit;
            r_stop_err <= r_stop_err | ~w_bit;
          end
          default: ;
        endcase
      end

      r_rx_valid  <= w_valid_set;
      r_break_det <= w_brk_set;
      if (w_valid_set) begin
        r_rx_data    <= r_shift;
        r_parity_err <= par_mismatch(r_shift, r_par_bit);
        r_frame_err  <= w_frame_err;
      end
    end
  end

  assign rx_valid   = r_rx_valid;
  assign rx_data    = r_rx_data;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign break_det  = r_break_det;

endmodule
